// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and the minimum legal
// address width. Functions work on 32-bit values; callers zero-extend and
// truncate to their own pointer width.
package fifo_pkg;

  localparam int ADDR_MIN = 2;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_sync.sv
// Combinational Gray-to-binary converter of parametrised width. Used on the
// synchronised opposite-domain pointer by both the write and read sides.
module gray2bin_sync #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at and above it; written as a
  // reduction per bit so no bit depends on another output bit.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[W-1:gi];
    end
  endgenerate

endmodule

// File: rtl/wptr_full_lvl.sv
// Write-side pointer and status block of the async FIFO.
// Holds the binary/Gray write pointers, derives full, fill level and
// almost-full from the synchronised Gray read pointer.
// Compile option: WPTR_OVF_EN adds the sticky overflow flag wovf; without it
// wovf is tied low and wovf_clr is ignored.
module wptr_full_lvl
  import fifo_pkg::*;
#(
  parameter int ADDR = 3
) (
  input  logic            wclk,
  input  logic            wrst,
  input  logic            winc,
  input  logic [ADDR:0]   wq2_rptr,
  input  logic [ADDR:0]   waf_thresh,
  input  logic            wovf_clr,
  output logic [ADDR:0]   wptr,
  output logic [ADDR-1:0] waddr,
  output logic            wfull,
  output logic            wafull,
  output logic [ADDR:0]   wlevel,
  output logic            wovf
);

  localparam int PW = ADDR + 1;

  generate
    if (ADDR < ADDR_MIN) begin : g_addr_chk
      $error("wptr_full_lvl: ADDR must be at least %0d", ADDR_MIN);
    end
  endgenerate

  logic [ADDR:0] r_wbin;
  logic [ADDR:0] r_wptr;
  logic          r_wfull;
  logic          r_wafull;
  logic [ADDR:0] r_wlevel;

  logic          w_accept;
  logic [ADDR:0] w_wbinnext;
  logic [ADDR:0] w_wgraynext;
  logic [ADDR:0] w_rbin;
  logic [ADDR:0] w_levelnext;
  logic [ADDR:0] w_full_cmp;
  logic          w_fullnext;
  logic          w_wafullnext;

  gray2bin_sync #(.W(PW)) u_rptr_g2b (
    .i_gray (wq2_rptr),
    .o_bin  (w_rbin)
  );

  // Next-state pointer arithmetic. Full compares against the read pointer
  // with its two MSBs inverted: same slot, one lap ahead.
  always_comb begin
    w_accept     = winc & ~r_wfull;
    w_wbinnext   = r_wbin + PW'(w_accept);
    w_wgraynext  = PW'(bin2gray(32'(w_wbinnext)));
    w_full_cmp   = {~wq2_rptr[ADDR:ADDR-1], wq2_rptr[ADDR-2:0]};
    w_fullnext   = (w_wgraynext == w_full_cmp);
    w_levelnext  = w_wbinnext - w_rbin;
    w_wafullnext = (w_levelnext >= waf_thresh);
  end

  // Pointer, level and status registers; reset clears them immediately.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wbin   <= '0;
      r_wptr   <= '0;
      r_wfull  <= 1'b0;
      r_wafull <= 1'b0;
      r_wlevel <= '0;
    end else begin
      r_wbin   <= w_wbinnext;
      r_wptr   <= w_wgraynext;
      r_wfull  <= w_fullnext;
      r_wafull <= w_wafullnext;
      r_wlevel <= w_levelnext;
    end
  end

`ifdef WPTR_OVF_EN
  logic r_wovf;

  // Sticky overflow: a rejected write sets it, and set beats a same-cycle clear.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wovf <= 1'b0;
    end else if (winc & r_wfull) begin
      r_wovf <= 1'b1;
    end else if (wovf_clr) begin
      r_wovf <= 1'b0;
    end
  end

  assign wovf = r_wovf;
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = wovf_clr;
  assign wovf = 1'b0;
`endif

  assign wptr   = r_wptr;
  assign waddr  = r_wbin[ADDR-1:0];
  assign wfull  = r_wfull;
  assign wafull = r_wafull;
  assign wlevel = r_wlevel;

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Bench for wptr_full_lvl with ADDR = 3: reset, fill, almost-full, overflow,
// drain and wrap-around, using a vector table and an expected-result queue.
module tb_wptr_full_lvl;

  localparam int ADDR = 3;
`ifdef WPTR_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic            wclk = 1'b0;
  logic            wrst = 1'b1;
  logic            winc = 1'b0;
  logic [ADDR:0]   wq2_rptr = '0;
  logic [ADDR:0]   waf_thresh = 4'd6;
  logic            wovf_clr = 1'b0;
  logic [ADDR:0]   wptr;
  logic [ADDR-1:0] waddr;
  logic            wfull;
  logic            wafull;
  logic [ADDR:0]   wlevel;
  logic            wovf;

  int n_tests = 0;
  int n_fail  = 0;

  wptr_full_lvl #(.ADDR(ADDR)) dut (
    .wclk       (wclk),
    .wrst       (wrst),
    .winc       (winc),
    .wq2_rptr   (wq2_rptr),
    .waf_thresh (waf_thresh),
    .wovf_clr   (wovf_clr),
    .wptr       (wptr),
    .waddr      (waddr),
    .wfull      (wfull),
    .wafull     (wafull),
    .wlevel     (wlevel),
    .wovf       (wovf)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic       winc;
    logic [3:0] rptr;
    logic [3:0] thr;
    logic       clr;
    logic [3:0] e_wptr;
    logic [2:0] e_waddr;
    logic       e_full;
    logic       e_afull;
    logic [3:0] e_level;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(logic wi, logic [3:0] rp, logic [3:0] th, logic cl,
                              logic [3:0] ep, logic [2:0] ea, logic ef,
                              logic eaf, logic [3:0] el, logic eo);
    vec_t v;
    v.winc = wi; v.rptr = rp; v.thr = th; v.clr = cl;
    v.e_wptr = ep; v.e_waddr = ea; v.e_full = ef;
    v.e_afull = eaf; v.e_level = el; v.e_ovf = eo;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, then compare after the edge.
  task automatic run_vec(input int idx);
    vec_t e;
    @(negedge wclk);
    winc       = vecs[idx].winc;
    wq2_rptr   = vecs[idx].rptr;
    waf_thresh = vecs[idx].thr;
    wovf_clr   = vecs[idx].clr;
    exp_q.push_back(vecs[idx]);
    @(posedge wclk);
    #1;
    e = exp_q.pop_front();
    check("wptr",   idx, 32'(wptr),   32'(e.e_wptr));
    check("waddr",  idx, 32'(waddr),  32'(e.e_waddr));
    check("wfull",  idx, 32'(wfull),  32'(e.e_full));
    check("wafull", idx, 32'(wafull), 32'(e.e_afull));
    check("wlevel", idx, 32'(wlevel), 32'(e.e_level));
    check("wovf",   idx, 32'(wovf),   32'(e.e_ovf));
    $display("[TB] vec %0d winc=%0b rptr=%b thr=%0d clr=%0b -> wptr=%b waddr=%0d full=%0b afull=%0b lvl=%0d ovf=%0b",
             idx, e.winc, e.rptr, e.thr, e.clr, wptr, waddr, wfull, wafull, wlevel, wovf);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int n_a;

  initial begin
    // Part A: fill from empty with threshold 6, overflow, then drain.
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b0001, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b0011, 2, 0, 0, 2, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b0010, 3, 0, 0, 3, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b0110, 4, 0, 0, 4, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b0111, 5, 0, 0, 5, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b0101, 6, 0, 1, 6, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b0100, 7, 0, 1, 7, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b1100, 0, 1, 1, 8, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b1100, 0, 1, 1, 8, OVF_ON));
    vecs.push_back(mk(1, 4'b0000, 6, 1, 4'b1100, 0, 1, 1, 8, OVF_ON));
    vecs.push_back(mk(0, 4'b0000, 6, 1, 4'b1100, 0, 1, 1, 8, 0));
    vecs.push_back(mk(0, 4'b0001, 6, 0, 4'b1100, 0, 0, 1, 7, 0));
    vecs.push_back(mk(0, 4'b0011, 6, 0, 4'b1100, 0, 0, 1, 6, 0));
    vecs.push_back(mk(0, 4'b0010, 6, 0, 4'b1100, 0, 0, 0, 5, 0));
    vecs.push_back(mk(0, 4'b0110, 6, 0, 4'b1100, 0, 0, 0, 4, 0));
    n_a = vecs.size();
    // Part B (after reset): threshold 0, fill, then wrap-around fill.
    vecs.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b0001, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b0011, 2, 0, 0, 2, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b0010, 3, 0, 0, 3, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b0110, 4, 0, 0, 4, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b0111, 5, 0, 0, 5, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b0101, 6, 0, 1, 6, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b0100, 7, 0, 1, 7, 0));
    vecs.push_back(mk(1, 4'b0000, 6, 0, 4'b1100, 0, 1, 1, 8, 0));
    vecs.push_back(mk(0, 4'b1100, 6, 0, 4'b1100, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'b1100, 6, 0, 4'b1101, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 4'b1100, 6, 0, 4'b1111, 2, 0, 0, 2, 0));
    vecs.push_back(mk(1, 4'b1100, 6, 0, 4'b1110, 3, 0, 0, 3, 0));
    vecs.push_back(mk(1, 4'b1100, 6, 0, 4'b1010, 4, 0, 0, 4, 0));
    vecs.push_back(mk(1, 4'b1100, 6, 0, 4'b1011, 5, 0, 0, 5, 0));
    vecs.push_back(mk(1, 4'b1100, 6, 0, 4'b1001, 6, 0, 1, 6, 0));
    vecs.push_back(mk(1, 4'b1100, 6, 0, 4'b1000, 7, 0, 1, 7, 0));
    vecs.push_back(mk(1, 4'b1100, 6, 0, 4'b0000, 0, 1, 1, 8, 0));

    // Reset held: outputs all zero.
    #3;
    check("rst_wptr",  -1, 32'(wptr),   32'd0);
    check("rst_level", -1, 32'(wlevel), 32'd0);
    check("rst_full",  -1, 32'(wfull),  32'd0);
    @(negedge wclk);
    wrst = 1'b0;

    // Three writes, then reset asserted mid-cycle clears outputs at once.
    @(negedge wclk);
    winc = 1'b1;
    repeat (3) @(posedge wclk);
    #1;
    check("pre_rst_level", -2, 32'(wlevel), 32'd3);
    #2;
    wrst = 1'b1;
    #1;
    check("mid_rst_wptr",   -2, 32'(wptr),   32'd0);
    check("mid_rst_waddr",  -2, 32'(waddr),  32'd0);
    check("mid_rst_level",  -2, 32'(wlevel), 32'd0);
    check("mid_rst_full",   -2, 32'(wfull),  32'd0);
    check("mid_rst_afull",  -2, 32'(wafull), 32'd0);
    check("mid_rst_ovf",    -2, 32'(wovf),   32'd0);
    @(negedge wclk);
    winc = 1'b0;
    wq2_rptr = '0;
    wrst = 1'b0;
    @(posedge wclk);
    #1;
    check("rel_full",  -3, 32'(wfull),  32'd0);
    check("rel_level", -3, 32'(wlevel), 32'd0);

    for (int i = 0; i < n_a; i++) run_vec(i);

    // Reset between parts, checked without a clock edge.
    @(negedge wclk);
    winc = 1'b0;
    wq2_rptr = '0;
    wrst = 1'b1;
    #1;
    check("rst2_wptr",  -4, 32'(wptr),   32'd0);
    check("rst2_level", -4, 32'(wlevel), 32'd0);
    check("rst2_ovf",   -4, 32'(wovf),   32'd0);
    @(negedge wclk);
    wrst = 1'b0;

    for (int i = n_a; i < vecs.size(); i++) run_vec(i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
